regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL expose `clk`, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL expose `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL expose `req_a`, input, 1 bit: requester A write request, held until granted.
REQ-004 SHALL expose `lock_a`, input, 1 bit: requester A asks to keep ownership for consecutive writes.
REQ-005 SHALL expose `wreg_a`, input, 2 bits: requester A target register.
REQ-006 SHALL expose `wdata_a`, input, 32 bits: requester A write data.
REQ-007 SHALL expose `gnt_a`, output, 1 bit: combinational grant to A; a transfer occurs at any rising edge where `req_a` and `gnt_a` are both 1.
REQ-008 SHALL expose `req_b`/`lock_b`/`wreg_b`/`wdata_b`/`gnt_b`, with the same widths and meaning as the A-side ports, for requester B.
REQ-009 SHALL expose `RegWrite`, output, 1 bit: registered write-enable to the register file.
REQ-010 SHALL expose `WriteReg`, output, 2 bits: registered write address.
REQ-011 SHALL expose `WriteData`, output, 32 bits: registered write data.
REQ-012 SHALL expose `owner`, output, 2 bits: registered owner state, 00 = none, 01 = A, 10 = B.

Function
REQ-013 SHALL assert at most one of `gnt_a`/`gnt_b` in any cycle; a grant is never asserted without its matching req.
REQ-014 SHALL, in state IDLE with a single requester active, grant that requester.
REQ-015 SHALL, in IDLE with both requesting, grant the requester not granted last (round-robin, see REQ-025).
REQ-016 SHALL, on a transfer at edge N, drive `RegWrite`=1 with that requester's `wreg`/`wdata` on `WriteReg`/`WriteData` during cycle N+1 (latency 1).
REQ-017 SHALL drive `RegWrite`=0 in any cycle not following a transfer; `WriteReg`/`WriteData` hold their last values.
REQ-018 SHALL implement states IDLE, OWN_A and OWN_B; IDLE->OWN_x on a transfer to x with `lock_x`=1.
REQ-019 SHALL, in OWN_x, grant only x (when `req_x`=1) and count transfers in a 2-bit burst counter, cleared on entry.
REQ-020 SHALL leave OWN_x for IDLE when any of: a transfer with `lock_x`=0; `req_x`=0 for a cycle; the 4th transfer of the burst (BURST_MAX=4).
REQ-021 SHALL, on the forced release after BURST_MAX, treat x as last granted so a waiting other requester wins next IDLE arbitration.
REQ-022 SHALL allow back-to-back transfers every cycle, including IDLE->OWN_x->IDLE->grant-other with no idle bubble on `RegWrite`.

Reset
REQ-023 SHALL, while `reset`=0, force `RegWrite`=0, `WriteReg`=00, `WriteData`=0, `owner`=00, state=IDLE, burst counter=0, last-granted=B (so A wins the first tie).
REQ-024 SHALL, on reset asserted mid-burst, abandon ownership immediately with no pending write emitted after release.

Configuration
REQ-025 SHALL, with `REGFILE_ARB_RR_EN` defined, use round-robin tie-break per REQ-015; without it, A always wins IDLE ties and the last-granted register is not implemented; the lock/burst behaviour is identical in both builds.

Structure
REQ-026 SHALL take from shared package `regfile_arb_pkg`: the state enum (IDLE, OWN_A, OWN_B), owner encodings, BURST_MAX=4, REG_ADDR_W=2, DATA_W=32.
REQ-027 SHALL place the two-way tie-break in one sub-module `rr_pick2` (inputs: two reqs, last-granted; output: one-hot pick).

Verification
REQ-028 SHALL cover: after reset, `req_a`=1, `wreg_a`=11, `wdata_a`=A5A5A5A5 -> `gnt_a`=1 that cycle; next cycle `RegWrite`=1, `WriteReg`=11, `WriteData`=A5A5A5A5.
REQ-029 SHALL cover: both req held, no lock, RR build -> grants A,B,A,B on consecutive cycles; non-RR build -> A every cycle.
REQ-030 SHALL cover: A with `lock_a`=1 held and B requesting -> four A writes, `owner`=01, then B granted on the 5th cycle.
REQ-031 SHALL cover: A locked, drops `req_a` after 2 writes -> `owner`=00 the following cycle, B granted.
REQ-032 SHALL cover: `reset` pulled low during an OWN_B burst -> all outputs 0 asynchronously; after release, A wins the first tie.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The round-robin build is selected in regfile_wr_arbiter by REGFILE_ARB_RR_EN.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 2;
    localparam int DATA_W     = 32;
    localparam int BURST_MAX  = 4;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    // The entry transfer is taken in IDLE and the counter only sees transfers
    // made while owning, so the last burst transfer lands on count BURST_MAX-2.
    localparam logic [1:0] BURST_LAST = 2'(BURST_MAX - 2);

    // State encodings double as the owner encodings.
    typedef enum logic [1:0] {
        IDLE  = OWNER_NONE,
        OWN_A = OWNER_A,
        OWN_B = OWNER_B
    } state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wreg;
        logic [DATA_W-1:0]     wdata;
    } wr_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way tie-break: a lone requester always wins; on a tie the side that
// was not granted last wins. Output is one-hot {pick B, pick A}.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_b,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (req0 && req1)
            pick = last_b ? 2'b01 : 2'b10;
        else
            pick = {req1, req0};
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for a small register file with lockable bursts.
// Define REGFILE_ARB_RR_EN for round-robin tie-break; otherwise A wins ties.
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  lock_a,
    input  logic [REG_ADDR_W-1:0] wreg_a,
    input  logic [DATA_W-1:0]     wdata_a,
    output logic                  gnt_a,
    input  logic                  req_b,
    input  logic                  lock_b,
    input  logic [REG_ADDR_W-1:0] wreg_b,
    input  logic [DATA_W-1:0]     wdata_b,
    output logic                  gnt_b,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic [1:0]            owner
);

    state_e     state, state_nxt;
    logic [1:0] burst_cnt;
    logic       last_b;
    logic [1:0] pick;
    logic       xfer_a, xfer_b, xfer;
    wr_req_t    sel_req;

    assign xfer_a = req_a & gnt_a;
    assign xfer_b = req_b & gnt_b;
    assign xfer   = xfer_a | xfer_b;

`ifdef REGFILE_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_b <= 1'b1;
        else if (xfer)
            last_b <= xfer_b;
    end
`else
    // Fixed priority: pretending B was always granted last makes A win ties.
    assign last_b = 1'b1;
`endif

    rr_pick2 u_pick (
        .req0   (req_a),
        .req1   (req_b),
        .last_b (last_b),
        .pick   (pick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // An owner keeps the bus only while it requests, keeps lock high and has
    // burst budget left; with req high in OWN_x a transfer is guaranteed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer_a && lock_a)
                    state_nxt = OWN_A;
                else if (xfer_b && lock_b)
                    state_nxt = OWN_B;
            end
            OWN_A: begin
                if (!req_a || !lock_a || burst_cnt == BURST_LAST)
                    state_nxt = IDLE;
            end
            OWN_B: begin
                if (!req_b || !lock_b || burst_cnt == BURST_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        case (state)
            IDLE:    {gnt_b, gnt_a} = pick;
            OWN_A:   gnt_a = req_a;
            OWN_B:   gnt_b = req_b;
            default: ;
        endcase
    end

    assign owner = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            burst_cnt <= 2'd0;
        else if (state == IDLE)
            burst_cnt <= 2'd0;
        else if (xfer)
            burst_cnt <= burst_cnt + 2'd1;
    end

    assign sel_req = xfer_b ? wr_req_t'{wreg: wreg_b, wdata: wdata_b}
                            : wr_req_t'{wreg: wreg_a, wdata: wdata_a};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= xfer;
            if (xfer) begin
                WriteReg  <= sel_req.wreg;
                WriteData <= sel_req.wdata;
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(gnt_a && gnt_b));
    a_gnt_a_req: assert property (@(posedge clk) disable iff (!reset)
        gnt_a |-> req_a);
    a_gnt_b_req: assert property (@(posedge clk) disable iff (!reset)
        gnt_b |-> req_b);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter; expectations adapt to REGFILE_ARB_RR_EN.
module tb_regfile_wr_arbiter;

`ifdef REGFILE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        req_a = 1'b0, lock_a = 1'b0, req_b = 1'b0, lock_b = 1'b0;
    logic [1:0]  wreg_a = 2'b00, wreg_b = 2'b00;
    logic [31:0] wdata_a = 32'h0, wdata_b = 32'h0;
    logic        gnt_a, gnt_b, RegWrite;
    logic [1:0]  WriteReg, owner;
    logic [31:0] WriteData;
    int          tests = 0, fails = 0;

    regfile_wr_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .lock_a(lock_a), .wreg_a(wreg_a), .wdata_a(wdata_a), .gnt_a(gnt_a),
        .req_b(req_b), .lock_b(lock_b), .wreg_b(wreg_b), .wdata_b(wdata_b), .gnt_b(gnt_b),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if ({RegWrite, WriteReg, WriteData, owner, gnt_b, gnt_a} !== 39'h0) begin
            fails++;
            $display("FAIL reset_state got rw=%b reg=%b data=%h own=%b gnt=%b%b required all zero",
                     RegWrite, WriteReg, WriteData, owner, gnt_b, gnt_a);
        end
        tick();
        reset = 1'b1;
        #1;
        tests++;
        if ({RegWrite, owner} !== 3'b000) begin
            fails++;
            $display("FAIL reset_release got rw=%b own=%b required 0 00", RegWrite, owner);
        end
    endtask

    task automatic test_single;
        req_a = 1'b1; wreg_a = 2'b11; wdata_a = 32'hA5A5_A5A5;
        #1;
        tests++;
        if ({gnt_b, gnt_a} !== 2'b01) begin
            fails++;
            $display("FAIL single_a_gnt got %b%b required 01", gnt_b, gnt_a);
        end
        tick();
        req_a = 1'b0;
        tests++;
        if ({RegWrite, WriteReg, WriteData, owner} !== {1'b1, 2'b11, 32'hA5A5_A5A5, 2'b00}) begin
            fails++;
            $display("FAIL single_a_write got rw=%b reg=%b data=%h own=%b required 1 11 a5a5a5a5 00",
                     RegWrite, WriteReg, WriteData, owner);
        end
        tick();
        tests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b0, 2'b11, 32'hA5A5_A5A5}) begin
            fails++;
            $display("FAIL single_a_hold got rw=%b reg=%b data=%h required 0 11 a5a5a5a5",
                     RegWrite, WriteReg, WriteData);
        end
        req_b = 1'b1; wreg_b = 2'b01; wdata_b = 32'h1234_5678;
        #1;
        tests++;
        if ({gnt_b, gnt_a} !== 2'b10) begin
            fails++;
            $display("FAIL single_b_gnt got %b%b required 10", gnt_b, gnt_a);
        end
        tick();
        req_b = 1'b0;
        tests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 2'b01, 32'h1234_5678}) begin
            fails++;
            $display("FAIL single_b_write got rw=%b reg=%b data=%h required 1 01 12345678",
                     RegWrite, WriteReg, WriteData);
        end
        tick();
    endtask

    task automatic test_tie;
        logic [1:0]  exp_g;
        logic [33:0] exp_w;
        req_a = 1'b1; wreg_a = 2'b10; wdata_a = 32'h1111_1111;
        req_b = 1'b1; wreg_b = 2'b01; wdata_b = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            exp_g = (RR && (i % 2 == 1)) ? 2'b10 : 2'b01;
            exp_w = exp_g[0] ? {2'b10, 32'h1111_1111} : {2'b01, 32'h2222_2222};
            #1;
            tests++;
            if ({gnt_b, gnt_a} !== exp_g) begin
                fails++;
                $display("FAIL tie_gnt[%0d] got %b%b required %b", i, gnt_b, gnt_a, exp_g);
            end
            tick();
            tests++;
            if ({RegWrite, WriteReg, WriteData, owner} !== {1'b1, exp_w, 2'b00}) begin
                fails++;
                $display("FAIL tie_write[%0d] got rw=%b reg=%b data=%h own=%b required 1 %b %h 00",
                         i, RegWrite, WriteReg, WriteData, owner, exp_w[33:32], exp_w[31:0]);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
    endtask

    task automatic test_burst;
        logic [1:0] exp_own;
        req_a = 1'b1; lock_a = 1'b1; wreg_a = 2'b10;
        req_b = 1'b1; lock_b = 1'b0; wreg_b = 2'b01; wdata_b = 32'hBBBB_0000;
        for (int i = 0; i < 4; i++) begin
            wdata_a = 32'hA000_0000 + 32'(i);
            #1;
            exp_own = (i == 0) ? 2'b00 : 2'b01;
            tests++;
            if ({gnt_b, gnt_a, owner} !== {2'b01, exp_own}) begin
                fails++;
                $display("FAIL burst_gnt[%0d] got gnt=%b%b own=%b required 01 %b",
                         i, gnt_b, gnt_a, owner, exp_own);
            end
            tick();
            exp_own = (i == 3) ? 2'b00 : 2'b01;
            tests++;
            if ({RegWrite, WriteData, owner} !== {1'b1, 32'hA000_0000 + 32'(i), exp_own}) begin
                fails++;
                $display("FAIL burst_write[%0d] got rw=%b data=%h own=%b required 1 %h %b",
                         i, RegWrite, WriteData, owner, 32'hA000_0000 + 32'(i), exp_own);
            end
        end
        wdata_a = 32'hA000_0004;
        #1;
        tests++;
        if ({gnt_b, gnt_a} !== (RR ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL burst_after_gnt got %b%b required %b", gnt_b, gnt_a, RR ? 2'b10 : 2'b01);
        end
        tick();
        tests++;
        if ({WriteData, owner} !== (RR ? {32'hBBBB_0000, 2'b00} : {32'hA000_0004, 2'b01})) begin
            fails++;
            $display("FAIL burst_after_write got data=%h own=%b required %h %b", WriteData, owner,
                     RR ? 32'hBBBB_0000 : 32'hA000_0004, RR ? 2'b00 : 2'b01);
        end
        req_a = 1'b0; lock_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_drop;
        req_a = 1'b1; lock_a = 1'b1; wdata_a = 32'hC000_0001;
        req_b = 1'b1; lock_b = 1'b0; wdata_b = 32'hD000_0001;
        tick();
        #1;
        tests++;
        if ({gnt_b, gnt_a, owner} !== 4'b0101) begin
            fails++;
            $display("FAIL drop_second_gnt got gnt=%b%b own=%b required 01 01", gnt_b, gnt_a, owner);
        end
        tick();
        req_a = 1'b0;
        #1;
        tests++;
        if ({gnt_b, gnt_a, owner} !== 4'b0001) begin
            fails++;
            $display("FAIL drop_no_gnt got gnt=%b%b own=%b required 00 01", gnt_b, gnt_a, owner);
        end
        tick();
        tests++;
        if ({RegWrite, owner, gnt_b, gnt_a} !== 5'b0_00_10) begin
            fails++;
            $display("FAIL drop_release got rw=%b own=%b gnt=%b%b required 0 00 10",
                     RegWrite, owner, gnt_b, gnt_a);
        end
        tick();
        req_b = 1'b0;
        tests++;
        if ({RegWrite, WriteData} !== {1'b1, 32'hD000_0001}) begin
            fails++;
            $display("FAIL drop_b_write got rw=%b data=%h required 1 d0000001", RegWrite, WriteData);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        req_a = 1'b1; lock_a = 1'b1; wdata_a = 32'hE000_0001;
        req_b = 1'b1; lock_b = 1'b0; wdata_b = 32'hF000_0001; wreg_b = 2'b11;
        tick();
        tests++;
        if ({RegWrite, WriteData, owner} !== {1'b1, 32'hE000_0001, 2'b01}) begin
            fails++;
            $display("FAIL b2b_first got rw=%b data=%h own=%b required 1 e0000001 01",
                     RegWrite, WriteData, owner);
        end
        lock_a = 1'b0; wdata_a = 32'hE000_0002;
        tick();
        tests++;
        if ({RegWrite, WriteData, owner} !== {1'b1, 32'hE000_0002, 2'b00}) begin
            fails++;
            $display("FAIL b2b_unlock got rw=%b data=%h own=%b required 1 e0000002 00",
                     RegWrite, WriteData, owner);
        end
        req_a = 1'b0;
        #1;
        tests++;
        if ({gnt_b, gnt_a} !== 2'b10) begin
            fails++;
            $display("FAIL b2b_other_gnt got %b%b required 10", gnt_b, gnt_a);
        end
        tick();
        req_b = 1'b0;
        tests++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 2'b11, 32'hF000_0001}) begin
            fails++;
            $display("FAIL b2b_other_write got rw=%b reg=%b data=%h required 1 11 f0000001",
                     RegWrite, WriteReg, WriteData);
        end
        tick();
        tests++;
        if ({RegWrite, WriteData} !== {1'b0, 32'hF000_0001}) begin
            fails++;
            $display("FAIL b2b_idle got rw=%b data=%h required 0 f0000001", RegWrite, WriteData);
        end
    endtask

    task automatic test_reset_mid;
        req_b = 1'b1; lock_b = 1'b1; wreg_b = 2'b10; wdata_b = 32'h5555_0001;
        tick();
        wdata_b = 32'h5555_0002;
        tick();
        tests++;
        if ({RegWrite, WriteData, owner} !== {1'b1, 32'h5555_0002, 2'b10}) begin
            fails++;
            $display("FAIL rstmid_own_b got rw=%b data=%h own=%b required 1 55550002 10",
                     RegWrite, WriteData, owner);
        end
        #2;
        reset = 1'b0; req_b = 1'b0; lock_b = 1'b0;
        #1;
        tests++;
        if ({RegWrite, WriteReg, WriteData, owner, gnt_b, gnt_a} !== 39'h0) begin
            fails++;
            $display("FAIL rstmid_async got rw=%b reg=%b data=%h own=%b gnt=%b%b required all zero",
                     RegWrite, WriteReg, WriteData, owner, gnt_b, gnt_a);
        end
        tick();
        tests++;
        if ({RegWrite, owner} !== 3'b000) begin
            fails++;
            $display("FAIL rstmid_held got rw=%b own=%b required 0 00", RegWrite, owner);
        end
        req_a = 1'b1; wreg_a = 2'b01; wdata_a = 32'h7777_7777;
        req_b = 1'b1; wdata_b = 32'h8888_8888;
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({gnt_b, gnt_a} !== 2'b01) begin
            fails++;
            $display("FAIL rstmid_first_tie got %b%b required 01", gnt_b, gnt_a);
        end
        tick();
        req_a = 1'b0; req_b = 1'b0;
        tests++;
        if ({RegWrite, WriteReg, WriteData, owner} !== {1'b1, 2'b01, 32'h7777_7777, 2'b00}) begin
            fails++;
            $display("FAIL rstmid_after got rw=%b reg=%b data=%h own=%b required 1 01 77777777 00",
                     RegWrite, WriteReg, WriteData, owner);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_burst();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
